// File: rtl/vga_line_buffer_pkg.sv
// Shared screen geometry, fill-state encoding and pixel type for the display line buffer.
// The row helper maps a display line to the VRAM row that must be ready for the next line.
package vga_line_buffer_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int X_W          = 10;
    localparam int Y_W          = 10;
    localparam int ROW_W        = 9;

    typedef logic [23:0] rgb888_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        READY
    } fill_state_e;

    // Next line to prefetch; the last visible line wraps back to row 0.
    function automatic logic [ROW_W-1:0] next_row(input logic [Y_W-1:0] y, input int screen_h);
        logic [Y_W-1:0] inc;
        inc = y + 1'b1;
        return (y == Y_W'(screen_h - 1)) ? '0 : inc[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/vga_line_buffer_if.sv
// Row-stream link between the VRAM controller (master) and the display line buffer (slave).
// The buffer requests a row; the controller streams that row back as indexed pixel writes.
interface vga_line_buffer_if;
    import vga_line_buffer_pkg::*;

    logic             VGA_we;
    logic [X_W-1:0]   VGA_x;
    rgb888_t          VGA_data;
    logic             VGA_re;
    logic [ROW_W-1:0] VGA_y;

    modport master (
        output VGA_we,
        output VGA_x,
        output VGA_data,
        input  VGA_re,
        input  VGA_y
    );

    modport slave (
        input  VGA_we,
        input  VGA_x,
        input  VGA_data,
        output VGA_re,
        output VGA_y
    );

endinterface

// File: rtl/vga_line_buffer_line_ram.sv
// One scanline bank: synchronous write port plus registered read port.
// A disabled read returns zero so the parent can merge both banks with a plain OR.
module vga_line_buffer_line_ram
    import vga_line_buffer_pkg::*;
#(
    parameter int DEPTH  = SCREEN_W_DEF,
    parameter int ADDR_W = X_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  rgb888_t           wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output rgb888_t           rd_data
);

    rgb888_t mem [DEPTH];
    rgb888_t rd_data_q;
    rgb888_t rd_data_d;

    // Storage itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_line_buffer.sv
// Double-buffered scanline store: the front bank feeds the DAC while the back bank is
// filled from the VRAM row stream; banks swap on line_start once the back bank is complete.
module vga_line_buffer
    import vga_line_buffer_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           line_start,
    input  logic [Y_W-1:0] disp_y,
    input  logic [X_W-1:0] disp_x,
    input  logic           disp_active,
    input  logic           underrun_clr,
    vga_line_buffer_if.slave vram,
    output rgb888_t        pix_rgb,
    output logic           underrun
);

    localparam logic [X_W-1:0] LAST_X  = X_W'(SCREEN_W - 1);
    localparam logic [X_W-1:0] X_LIMIT = X_W'(SCREEN_W);

    fill_state_e      state_q, state_d;
    logic             vga_re_q, vga_re_d;
    logic [ROW_W-1:0] vga_y_q, vga_y_d;
    logic             underrun_q, underrun_d;
    logic             front_q, front_d;

    logic    wr_ok;
    logic    fill_done;
    logic    rd_ok;
    logic    accept;
    logic    underrun_set;
    rgb888_t rd_data0;
    rgb888_t rd_data1;

    assign wr_ok     = (state_q == FILL) && vram.VGA_we && (vram.VGA_x < X_LIMIT);
    assign fill_done = wr_ok && (vram.VGA_x == LAST_X);
    assign rd_ok     = disp_active && (disp_x < X_LIMIT);

    // A line_start coinciding with the final write counts as READY: swap and re-request.
    always_comb begin
        state_d      = state_q;
        vga_y_d      = vga_y_q;
        front_d      = front_q;
        accept       = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    accept = 1'b1;
                end
            end
            REQ: begin
                state_d = FILL;
                if (line_start) begin
                    underrun_set = 1'b1;
                end
            end
            FILL: begin
                if (fill_done && line_start) begin
                    front_d = ~front_q;
                    accept  = 1'b1;
                end else if (fill_done) begin
                    state_d = READY;
                end else if (line_start) begin
                    underrun_set = 1'b1;
                end
            end
            READY: begin
                if (line_start) begin
                    front_d = ~front_q;
                    accept  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = REQ;
            vga_y_d = next_row(disp_y, SCREEN_H);
        end
        vga_re_d   = accept;
        underrun_d = underrun_set | (underrun_q & ~underrun_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vga_re_q   <= 1'b0;
            vga_y_q    <= '0;
            underrun_q <= 1'b0;
            front_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vga_re_q   <= vga_re_d;
            vga_y_q    <= vga_y_d;
            underrun_q <= underrun_d;
            front_q    <= front_d;
        end
    end

    // Bank 0 is front when front_q==0; writes always target the other bank.
    vga_line_buffer_line_ram #(
        .DEPTH  (SCREEN_W),
        .ADDR_W (X_W)
    ) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && front_q),
        .wr_addr (vram.VGA_x),
        .wr_data (vram.VGA_data),
        .rd_en   (rd_ok && !front_q),
        .rd_addr (disp_x),
        .rd_data (rd_data0)
    );

    vga_line_buffer_line_ram #(
        .DEPTH  (SCREEN_W),
        .ADDR_W (X_W)
    ) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !front_q),
        .wr_addr (vram.VGA_x),
        .wr_data (vram.VGA_data),
        .rd_en   (rd_ok && front_q),
        .rd_addr (disp_x),
        .rd_data (rd_data1)
    );

    assign pix_rgb     = rd_data0 | rd_data1;
    assign underrun    = underrun_q;
    assign vram.VGA_re = vga_re_q;
    assign vram.VGA_y  = vga_y_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed bench for the double-buffered VGA line store: fill, swap, wrap, underrun,
// coincident completion, ignored writes and asynchronous reset.
module tb_vga_line_buffer;
    import vga_line_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_start;
    logic [9:0] disp_y;
    logic [9:0] disp_x;
    logic       disp_active;
    logic       underrun_clr;
    rgb888_t    pix_rgb;
    logic       underrun;

    int tests = 0;
    int fails = 0;

    vga_line_buffer_if bus ();

    vga_line_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .line_start   (line_start),
        .disp_y       (disp_y),
        .disp_x       (disp_x),
        .disp_active  (disp_active),
        .underrun_clr (underrun_clr),
        .vram         (bus),
        .pix_rgb      (pix_rgb),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input logic [9:0] y);
        line_start = 1'b1;
        disp_y     = y;
        tick();
        line_start = 1'b0;
    endtask

    task automatic write_range(input int lo, input int hi, input logic [7:0] tag);
        for (int x = lo; x <= hi; x++) begin
            bus.VGA_we   = 1'b1;
            bus.VGA_x    = 10'(x);
            bus.VGA_data = {tag, 16'(x)};
            tick();
        end
        bus.VGA_we = 1'b0;
    endtask

    task automatic read_px(input int x);
        disp_active = 1'b1;
        disp_x      = 10'(x);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; line_start = 0; disp_y = 0; disp_x = 0; disp_active = 0; underrun_clr = 0;
        bus.VGA_we = 0; bus.VGA_x = 0; bus.VGA_data = 0;
        tick(); tick();
        if (bus.VGA_re !== 1'b0) begin $display("FAIL reset_re: got %0b expected 0", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd0) begin $display("FAIL reset_y: got %0d expected 0", bus.VGA_y); fails++; end
        tests++;
        if (pix_rgb !== 24'h0) begin $display("FAIL reset_pix: got %h expected 000000", pix_rgb); fails++; end
        tests++;
        if (underrun !== 1'b0) begin $display("FAIL reset_underrun: got %0b expected 0", underrun); fails++; end
        tests++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_fill();
        start_line(10'd5);
        if (bus.VGA_re !== 1'b1) begin $display("FAIL first_req_re: got %0b expected 1", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd6) begin $display("FAIL first_req_y: got %0d expected 6", bus.VGA_y); fails++; end
        tests++;
        if (underrun !== 1'b0) begin $display("FAIL first_req_underrun: got %0b expected 0", underrun); fails++; end
        tests++;
        tick();
        if (bus.VGA_re !== 1'b0) begin $display("FAIL req_pulse_width: got %0b expected 0", bus.VGA_re); fails++; end
        tests++;
        write_range(0, 639, 8'h00);
        if (bus.VGA_y !== 9'd6) begin $display("FAIL y_held_during_fill: got %0d expected 6", bus.VGA_y); fails++; end
        tests++;
        start_line(10'd6);
        if (bus.VGA_re !== 1'b1) begin $display("FAIL ready_req_re: got %0b expected 1", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd7) begin $display("FAIL ready_req_y: got %0d expected 7", bus.VGA_y); fails++; end
        tests++;
        read_px(10);
        if (pix_rgb !== 24'h00000A) begin $display("FAIL pix_x10: got %h expected 00000a", pix_rgb); fails++; end
        tests++;
        read_px(639);
        if (pix_rgb !== 24'h00027F) begin $display("FAIL pix_x639: got %h expected 00027f", pix_rgb); fails++; end
        tests++;
        disp_active = 1'b0;
        disp_x      = 10'd10;
        tick();
        if (pix_rgb !== 24'h0) begin $display("FAIL pix_blank: got %h expected 000000", pix_rgb); fails++; end
        tests++;
        read_px(700);
        if (pix_rgb !== 24'h0) begin $display("FAIL pix_x700: got %h expected 000000", pix_rgb); fails++; end
        tests++;
        disp_active = 1'b0;
    endtask

    task automatic test_wrap();
        write_range(0, 639, 8'h01);
        start_line(10'd479);
        if (bus.VGA_re !== 1'b1) begin $display("FAIL wrap_re: got %0b expected 1", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd0) begin $display("FAIL wrap_y: got %0d expected 0", bus.VGA_y); fails++; end
        tests++;
        read_px(10);
        if (pix_rgb !== 24'h01000A) begin $display("FAIL wrap_pix: got %h expected 01000a", pix_rgb); fails++; end
        tests++;
        disp_active = 1'b0;
    endtask

    task automatic test_underrun();
        write_range(0, 300, 8'h02);
        start_line(10'd100);
        if (underrun !== 1'b1) begin $display("FAIL underrun_set: got %0b expected 1", underrun); fails++; end
        tests++;
        if (bus.VGA_re !== 1'b0) begin $display("FAIL underrun_no_req: got %0b expected 0", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd0) begin $display("FAIL underrun_y_held: got %0d expected 0", bus.VGA_y); fails++; end
        tests++;
        read_px(10);
        if (pix_rgb !== 24'h01000A) begin $display("FAIL underrun_repeat_line: got %h expected 01000a", pix_rgb); fails++; end
        tests++;
        disp_active = 1'b0;
        write_range(301, 639, 8'h02);
        if (underrun !== 1'b1) begin $display("FAIL underrun_sticky: got %0b expected 1", underrun); fails++; end
        tests++;
        start_line(10'd200);
        if (bus.VGA_re !== 1'b1) begin $display("FAIL after_underrun_re: got %0b expected 1", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd201) begin $display("FAIL after_underrun_y: got %0d expected 201", bus.VGA_y); fails++; end
        tests++;
        read_px(10);
        if (pix_rgb !== 24'h02000A) begin $display("FAIL after_underrun_pix10: got %h expected 02000a", pix_rgb); fails++; end
        tests++;
        read_px(300);
        if (pix_rgb !== 24'h02012C) begin $display("FAIL after_underrun_pix300: got %h expected 02012c", pix_rgb); fails++; end
        tests++;
        disp_active  = 1'b0;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        if (underrun !== 1'b0) begin $display("FAIL underrun_clear: got %0b expected 0", underrun); fails++; end
        tests++;
    endtask

    task automatic test_coincident();
        write_range(0, 638, 8'h03);
        bus.VGA_we   = 1'b1;
        bus.VGA_x    = 10'd639;
        bus.VGA_data = {8'h03, 16'd639};
        line_start   = 1'b1;
        disp_y       = 10'd300;
        tick();
        line_start = 1'b0;
        bus.VGA_we = 1'b0;
        if (bus.VGA_re !== 1'b1) begin $display("FAIL coincident_re: got %0b expected 1", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd301) begin $display("FAIL coincident_y: got %0d expected 301", bus.VGA_y); fails++; end
        tests++;
        if (underrun !== 1'b0) begin $display("FAIL coincident_underrun: got %0b expected 0", underrun); fails++; end
        tests++;
        read_px(639);
        if (pix_rgb !== 24'h03027F) begin $display("FAIL coincident_last_pix: got %h expected 03027f", pix_rgb); fails++; end
        tests++;
        read_px(5);
        if (pix_rgb !== 24'h030005) begin $display("FAIL coincident_pix5: got %h expected 030005", pix_rgb); fails++; end
        tests++;
        disp_active = 1'b0;
    endtask

    task automatic test_ignored_writes();
        bus.VGA_we   = 1'b1;
        bus.VGA_x    = 10'd700;
        bus.VGA_data = 24'hDEADBE;
        tick();
        bus.VGA_we = 1'b0;
        write_range(0, 639, 8'h04);
        bus.VGA_we   = 1'b1;
        bus.VGA_x    = 10'd10;
        bus.VGA_data = 24'hDEADBE;
        tick();
        bus.VGA_x = 10'd639;
        tick();
        bus.VGA_we = 1'b0;
        start_line(10'd10);
        if (bus.VGA_re !== 1'b1) begin $display("FAIL ignored_req_re: got %0b expected 1", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd11) begin $display("FAIL ignored_req_y: got %0d expected 11", bus.VGA_y); fails++; end
        tests++;
        read_px(10);
        if (pix_rgb !== 24'h04000A) begin $display("FAIL ready_write_ignored10: got %h expected 04000a", pix_rgb); fails++; end
        tests++;
        read_px(639);
        if (pix_rgb !== 24'h04027F) begin $display("FAIL ready_write_ignored639: got %h expected 04027f", pix_rgb); fails++; end
        tests++;
        disp_active = 1'b0;
        // Out-of-range index must not complete the fill; clear loses to a fresh underrun.
        bus.VGA_we   = 1'b1;
        bus.VGA_x    = 10'd700;
        bus.VGA_data = 24'h123456;
        tick();
        bus.VGA_we   = 1'b0;
        line_start   = 1'b1;
        underrun_clr = 1'b1;
        disp_y       = 10'd20;
        tick();
        line_start   = 1'b0;
        underrun_clr = 1'b0;
        if (underrun !== 1'b1) begin $display("FAIL set_beats_clear: got %0b expected 1", underrun); fails++; end
        tests++;
        if (bus.VGA_re !== 1'b0) begin $display("FAIL x700_no_complete_re: got %0b expected 0", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd11) begin $display("FAIL x700_y_held: got %0d expected 11", bus.VGA_y); fails++; end
        tests++;
    endtask

    task automatic test_reset_mid_fill();
        read_px(10);
        if (pix_rgb !== 24'h04000A) begin $display("FAIL pre_reset_pix: got %h expected 04000a", pix_rgb); fails++; end
        tests++;
        write_range(0, 2, 8'h05);
        #2;
        rst = 1'b1;
        #1;
        if (pix_rgb !== 24'h0) begin $display("FAIL async_reset_pix: got %h expected 000000", pix_rgb); fails++; end
        tests++;
        if (underrun !== 1'b0) begin $display("FAIL async_reset_underrun: got %0b expected 0", underrun); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd0) begin $display("FAIL async_reset_y: got %0d expected 0", bus.VGA_y); fails++; end
        tests++;
        if (bus.VGA_re !== 1'b0) begin $display("FAIL async_reset_re: got %0b expected 0", bus.VGA_re); fails++; end
        tests++;
        tick();
        rst         = 1'b0;
        disp_active = 1'b0;
        tick();
        start_line(10'd0);
        if (bus.VGA_re !== 1'b1) begin $display("FAIL post_reset_re: got %0b expected 1", bus.VGA_re); fails++; end
        tests++;
        if (bus.VGA_y !== 9'd1) begin $display("FAIL post_reset_y: got %0d expected 1", bus.VGA_y); fails++; end
        tests++;
        if (underrun !== 1'b0) begin $display("FAIL post_reset_underrun: got %0b expected 0", underrun); fails++; end
        tests++;
        read_px(5);
        if (pix_rgb !== 24'h030005) begin $display("FAIL ram_kept_pix5: got %h expected 030005", pix_rgb); fails++; end
        tests++;
        read_px(1);
        if (pix_rgb !== 24'h050001) begin $display("FAIL aborted_fill_pix1: got %h expected 050001", pix_rgb); fails++; end
        tests++;
        disp_active = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_wrap();
        test_underrun();
        test_coincident();
        test_ignored_writes();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
